i2c_target: RTL and testbench

I2C responder (target) for the synthesizer's two-wire control bus. It decodes START/STOP conditions and a 7-bit device address from oversampled SCL/SDA lines, and exposes an 8-bit auto-incrementing register pointer with write-strobe and read-fetch ports to a local register bank. It sits at the pad boundary next to the open-drain SDA buffer and lets the synth core be configured by any standard I2C initiator on the board.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_line_filter.sv | 52 +++++
 rtl/i2c_target.sv | 190 +++++++++++++++++++
 tb/tb_i2c_target.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: FSM state encodings, ACK/NACK bit values and the
// R/W bit position. Usable by both the target and an initiator.
package i2c_pkg;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h1A;
  localparam logic       ACK              = 1'b0;
  localparam logic       NACK             = 1'b1;
  localparam int         RW_BIT           = 0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// One bus line: 2-FF synchronizer, 3-sample agreement filter, and registered
// rise/fall pulses aligned with the filtered level (5 clocks pad-to-edge).
module i2c_line_filter (
  input  logic clock,
  input  logic reset,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q, sync_d;
  logic [1:0] hist_q, hist_d;
  logic       filt_q, filt_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;

  // NOTE: combinational blocks use blocking '=' and assign every output first,
  // so no latch can be inferred; the flop block below uses non-blocking '<='.
  always_comb begin
    sync_d = {sync_q[0], line_in};
    hist_d = {hist_q[0], sync_q[1]};
    filt_d = filt_q;
    if (sync_q[1] && (&hist_q))        filt_d = 1'b1;
    else if (!sync_q[1] && !(|hist_q)) filt_d = 1'b0;
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
  end

  // NOTE: the pipeline resets to the idle-bus level (high) so that releasing
  // reset on a quiet bus never produces a spurious edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= 2'b11;
      hist_q <= 2'b11;
      filt_q <= 1'b1;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
      filt_q <= filt_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign level = filt_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-bit auto-incrementing register pointer and
// write-strobe / read-fetch ports into a local register bank.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_drive_low,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  input  logic [7:0] rd_data,
  output logic       rd_en,
  output logic       busy
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_filter u_scl_filter (
    .clock(clock), .reset(reset), .line_in(scl_in),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter u_sda_filter (
    .clock(clock), .reset(reset), .line_in(sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  state_e     state_q, state_d;
  logic [6:0] shift_q, shift_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       rw_q, rw_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_en_q, wr_en_d;
  logic       rd_en_q, rd_en_d;
  logic       drive_q, drive_d;
  logic       busy_q, busy_d;

  logic       start_cond, stop_cond;
  logic [7:0] byte_in;

  assign start_cond = sda_fall & scl_lvl;
  assign stop_cond  = sda_rise & scl_lvl;
  assign byte_in    = {shift_q, sda_lvl};

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    rw_d       = rw_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    drive_d    = drive_q;
    busy_d     = busy_q;
    // Post-write increment lands the cycle after the strobe.
    reg_addr_d = wr_en_q ? reg_addr_q + 8'd1 : reg_addr_q;

    if (start_cond) begin
      state_d   = ST_DEV_ADDR;
      bit_cnt_d = 4'd0;
      drive_d   = 1'b0;
    end else if (stop_cond) begin
      state_d   = ST_IDLE;
      drive_d   = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = byte_in[6:0];
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ST_DEV_ADDR) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  busy_d  = 1'b1;
                  rw_d    = byte_in[RW_BIT];
                  state_d = ST_DEV_ACK;
                end else begin
                  busy_d  = 1'b0;
                  state_d = ST_IGNORE;
                end
              end else if (state_q == ST_REG_ADDR) begin
                reg_addr_d = byte_in;
                state_d    = ST_REG_ACK;
              end else begin
                wr_data_d = byte_in;
                wr_en_d   = 1'b1;
                state_d   = ST_WR_ACK;
              end
            end
          end
        end
        // bit_cnt 0: waiting to drive ACK; 1: ACK driven, waiting to release.
        ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd0) begin
              drive_d   = 1'b1;
              bit_cnt_d = 4'd1;
            end else begin
              drive_d   = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == ST_DEV_ACK && rw_q) begin
                rd_en_d = 1'b1;
                state_d = ST_RD_DATA;
              end else if (state_q == ST_DEV_ACK) begin
                state_d = ST_REG_ADDR;
              end else begin
                state_d = ST_WR_DATA;
              end
            end
          end
        end
        ST_RD_DATA: begin
          if (rd_en_q) begin
            shift_d = rd_data[6:0];
            drive_d = ~rd_data[7];
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              drive_d   = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = ST_RD_ACK;
            end else begin
              drive_d = ~shift_q[6];
              shift_d = {shift_q[5:0], 1'b0};
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise) begin
            if (sda_lvl == ACK) begin
              bit_cnt_d  = 4'd1;
              reg_addr_d = reg_addr_q + 8'd1;
            end else begin
              state_d = ST_IGNORE;
            end
          end else if (scl_fall && bit_cnt_q == 4'd1) begin
            bit_cnt_d = 4'd0;
            rd_en_d   = 1'b1;
            state_d   = ST_RD_DATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      rw_q       <= 1'b0;
      reg_addr_q <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      drive_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      rw_q       <= rw_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      drive_q    <= drive_d;
      busy_q     <= busy_d;
    end
  end

  assign sda_drive_low = drive_q;
  assign reg_addr      = reg_addr_q;
  assign wr_data       = wr_data_q;
  assign wr_en         = wr_en_q;
  assign rd_en         = rd_en_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: table-driven write transfers plus hand-written
// read, reset-during-read and glitch-rejection sequences.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 8;  // clocks per quarter SCL period

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_in, sda_in;
  logic       sda_drive_low, wr_en, rd_en, busy;
  logic [7:0] reg_addr, wr_data, rd_data;

  assign scl_in  = scl_m;
  assign sda_in  = sda_m & ~sda_drive_low;  // open-drain wired-AND
  assign rd_data = ~reg_addr;                // register-bank model

  i2c_target dut (
    .clock(clock), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
    .sda_drive_low(sda_drive_low), .reg_addr(reg_addr), .wr_data(wr_data),
    .wr_en(wr_en), .rd_data(rd_data), .rd_en(rd_en), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  logic [15:0] wr_log[$];
  logic [7:0]  rd_log[$];
  int          drive_cnt = 0;

  always @(negedge clock) begin
    if (wr_en) wr_log.push_back({reg_addr, wr_data});
    if (rd_en) rd_log.push_back(reg_addr);
    if (sda_drive_low) drive_cnt++;
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    sda_m = 1'b1; wait_clks(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wait_clks(Q);
      scl_m = 1'b1; wait_clks(2 * Q);
      scl_m = 1'b0; wait_clks(Q);
    end
    sda_m = 1'b1; wait_clks(Q);
    scl_m = 1'b1; wait_clks(Q);
    ack = sda_in; wait_clks(Q);
    scl_m = 1'b0; wait_clks(Q);
  endtask

  task automatic read_byte(output logic [7:0] b);
    sda_m = 1'b1;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      wait_clks(Q);
      scl_m = 1'b1; wait_clks(Q);
      b = {b[6:0], sda_in}; wait_clks(Q);
      scl_m = 1'b0; wait_clks(Q);
    end
  endtask

  task automatic send_ack(input logic a);
    sda_m = a;    wait_clks(Q);
    scl_m = 1'b1; wait_clks(2 * Q);
    scl_m = 1'b0; wait_clks(Q);
    sda_m = 1'b1;
  endtask

  // SDA low for n clocks starting with SCL high; SCL drops 3 clocks in.
  task automatic sda_pulse_then_scl_low(input int n);
    @(negedge clock) sda_m = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      if (k == 3) scl_m = 1'b0;
      if (k == n) sda_m = 1'b1;
    end
    wait_clks(Q);
  endtask

  typedef struct {
    logic [7:0]  dev;
    logic [7:0]  ptr;
    int          n;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic        exp_ack;
    int          exp_wr;
    logic [15:0] w0;
    logic [15:0] w1;
  } wvec_t;

  wvec_t vecs[4];

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic       ack;
    logic [7:0] b;
    int         base;
    int         dbase;

    vecs[0] = '{8'h34, 8'h0C, 1, 8'hA5, 8'h00, ACK,  1, 16'h0CA5, 16'h0000};
    vecs[1] = '{8'h34, 8'hFF, 2, 8'h11, 8'h22, ACK,  2, 16'hFF11, 16'h0022};
    vecs[2] = '{8'h36, 8'h00, 0, 8'h00, 8'h00, NACK, 0, 16'h0000, 16'h0000};
    vecs[3] = '{8'h34, 8'h7E, 2, 8'h3C, 8'hC3, ACK,  2, 16'h7E3C, 16'h7FC3};

    wait_clks(3);
    reset = 1'b0;
    wait_clks(1);
    check("rst_sda_drive_low", 16'(sda_drive_low), 16'h0);
    check("rst_reg_addr",      16'(reg_addr),      16'h0);
    check("rst_wr_data",       16'(wr_data),       16'h0);
    check("rst_wr_en",         16'(wr_en),         16'h0);
    check("rst_rd_en",         16'(rd_en),         16'h0);
    check("rst_busy",          16'(busy),          16'h0);
    wait_clks(10);

    for (int i = 0; i < 4; i++) begin
      base  = wr_log.size();
      dbase = drive_cnt;
      i2c_start();
      send_byte(vecs[i].dev, ack);
      check($sformatf("v%0d_dev_ack", i), 16'(ack), 16'(vecs[i].exp_ack));
      check($sformatf("v%0d_busy_mid", i), 16'(busy), 16'(vecs[i].exp_ack == ACK));
      send_byte(vecs[i].ptr, ack);
      check($sformatf("v%0d_ptr_ack", i), 16'(ack), 16'(vecs[i].exp_ack));
      for (int j = 0; j < vecs[i].n; j++) begin
        send_byte((j == 0) ? vecs[i].d0 : vecs[i].d1, ack);
        check($sformatf("v%0d_data%0d_ack", i, j), 16'(ack), 16'(vecs[i].exp_ack));
      end
      i2c_stop();
      wait_clks(10);
      check($sformatf("v%0d_busy_after_stop", i), 16'(busy), 16'h0);
      check($sformatf("v%0d_wr_count", i), 16'(wr_log.size() - base), 16'(vecs[i].exp_wr));
      if (vecs[i].exp_wr > 0 && wr_log.size() > base)
        check($sformatf("v%0d_wr0", i), wr_log[base], vecs[i].w0);
      if (vecs[i].exp_wr > 1 && wr_log.size() > base + 1)
        check($sformatf("v%0d_wr1", i), wr_log[base + 1], vecs[i].w1);
      if (vecs[i].exp_ack == NACK)
        check($sformatf("v%0d_no_drive", i), 16'(drive_cnt - dbase), 16'h0);
    end

    // Random read: pointer 0x05, repeated START, two bytes, ACK then NACK.
    base = rd_log.size();
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h05, ack);
    i2c_start();
    send_byte(8'h35, ack);
    check("rd_dev_ack", 16'(ack), 16'(ACK));
    check("rd_busy", 16'(busy), 16'h1);
    read_byte(b);
    check("rd_byte0", 16'(b), 16'h00FA);
    send_ack(ACK);
    read_byte(b);
    check("rd_byte1", 16'(b), 16'h00F9);
    send_ack(NACK);
    wait_clks(2 * Q);
    check("rd_released_after_nack", 16'(sda_drive_low), 16'h0);
    check("rd_en_count", 16'(rd_log.size() - base), 16'h2);
    if (rd_log.size() >= base + 2) begin
      check("rd_en_addr0", 16'(rd_log[base]),     16'h05);
      check("rd_en_addr1", 16'(rd_log[base + 1]), 16'h06);
    end
    check("rd_ptr_final", 16'(reg_addr), 16'h06);
    i2c_stop();
    wait_clks(10);
    check("rd_busy_after_stop", 16'(busy), 16'h0);

    // Reset while the target drives a 0 bit (pointer 0x80 -> data 0x7F, MSB 0).
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h80, ack);
    i2c_start();
    send_byte(8'h35, ack);
    wait_clks(Q);
    check("rst_mid_driving", 16'(sda_drive_low), 16'h1);
    reset = 1'b1;
    wait_clks(1);
    check("rst_mid_sda", 16'(sda_drive_low), 16'h0);
    check("rst_mid_busy", 16'(busy), 16'h0);
    check("rst_mid_reg_addr", 16'(reg_addr), 16'h0);
    reset = 1'b0;
    sda_m = 1'b1;
    scl_m = 1'b1;
    wait_clks(12);
    i2c_start();
    send_byte(8'h34, ack);
    check("post_rst_ack", 16'(ack), 16'(ACK));
    send_byte(8'h00, ack);
    i2c_stop();
    wait_clks(10);

    // Glitch rejection: a 2-clock pulse is not a START, a 4-clock one is.
    sda_pulse_then_scl_low(2);
    send_byte(8'h34, ack);
    check("glitch2_no_start_ack", 16'(ack), 16'(NACK));
    check("glitch2_busy", 16'(busy), 16'h0);
    i2c_stop();
    wait_clks(10);
    sda_pulse_then_scl_low(4);
    send_byte(8'h34, ack);
    check("pulse4_start_ack", 16'(ack), 16'(ACK));
    check("pulse4_busy", 16'(busy), 16'h1);
    i2c_stop();
    wait_clks(10);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
